muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width in bits (legal range 4..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request strobe, sampled only while ready=1.
REQ-005 SHALL have port op, input, 2 bits: 00 MUL, 01 DIV, 10/11 reserved.
REQ-006 SHALL have ports a and b, input, WIDTH bits each: a is multiplicand/dividend; b is multiplier/divisor.
REQ-007 SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port result_hi, output, WIDTH bits: MUL product upper half; DIV remainder.
REQ-010 SHALL have port result_lo, output, WIDTH bits: MUL product lower half; DIV quotient.
REQ-011 SHALL have port err, output, 1 bit: error flag, valid while done=1 and held afterwards.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 Accept: in IDLE with start=1, SHALL capture op, a and b, clear the bit counter, and enter RUN; a and b are don't-care afterwards.
REQ-014 RUN SHALL process one bit per cycle for exactly WIDTH cycles (shift-add for MUL, restoring shift-subtract for DIV), then enter DONE.
REQ-015 Latency: done SHALL assert exactly WIDTH+1 cycles after the accept cycle for a valid MUL or DIV.
REQ-016 DONE SHALL last one cycle with done=1, then return to IDLE; the next accept is possible in the cycle after DONE.
REQ-017 result_hi, result_lo and err SHALL become valid in DONE and hold until the next accept.
REQ-018 They SHALL be cleared to 0 at the next accept.
REQ-019 start SHALL be ignored in RUN and DONE: no queuing, no effect on the current operation.
REQ-020 MUL SHALL produce the full 2*WIDTH-bit product {result_hi, result_lo} with no truncation.
REQ-021 DIV SHALL give result_lo = floor(a/b) and result_hi = a mod b.
REQ-022 DIV with b=0 SHALL skip RUN and enter DONE on the cycle after accept (done at accept+1) with result_lo = all ones, result_hi = a, err=1.
REQ-023 A reserved op SHALL skip RUN and enter DONE on the cycle after accept with results 0 and err=1.
REQ-024 err SHALL be 0 for every valid, nonzero-divisor operation.

Reset
REQ-025 reset SHALL force IDLE from any state, including mid-RUN, aborting the operation.
REQ-026 While reset is high, and in the cycle after it falls, outputs SHALL be ready=1, done=0, result_hi=0, result_lo=0, err=0, and no done pulse SHALL be produced for the aborted operation.
REQ-027 reset SHALL take priority over start in the same cycle.

Configuration
REQ-028 With MULDIV_SIGNED_EN defined, the block SHALL add input port sgn (1 bit), captured at accept; sgn=1 treats a and b as two's complement.
REQ-029 Signed operations SHALL use operand magnitudes, with sign correction applied on the RUN-to-DONE transition so latency is unchanged.
REQ-030 For signed DIV, the quotient SHALL truncate toward zero and the remainder SHALL take the dividend's sign.
REQ-031 Signed DIV of the most negative value by -1 SHALL return result_lo = the most negative value, result_hi = 0, err=1.
REQ-032 Without MULDIV_SIGNED_EN, the sgn port SHALL be absent and all arithmetic SHALL be unsigned.

Structure
REQ-033 Package muldiv_pkg SHALL hold the op encodings (OP_MUL, OP_DIV), the state enum (ST_IDLE, ST_RUN, ST_DONE) and the counter-width function clog2(WIDTH+1).
REQ-034 One sub-module, muldiv_fsm, SHALL hold state, counter and handshake outputs; the datapath shift registers stay in muldiv_seq.

Verification
REQ-035 The bench SHALL cover, with WIDTH=8: MUL a=13 b=11 -> done at accept+9, result_hi=0x00, result_lo=0x8F, err=0.
REQ-036 The bench SHALL cover, with WIDTH=8: DIV a=200 b=7 -> result_lo=0x1C, result_hi=0x04, err=0, done at accept+9.
REQ-037 The bench SHALL cover, with WIDTH=8: DIV a=0x55 b=0 -> done at accept+1, result_lo=0xFF, result_hi=0x55, err=1.
REQ-038 The bench SHALL cover, with WIDTH=8: MUL 0xFF*0xFF with start re-pulsed during RUN -> single done, result_hi=0xFE, result_lo=0x01.
REQ-039 The bench SHALL cover, with WIDTH=8: reset on the 4th RUN cycle -> next cycle ready=1, done=0, results 0, no stray done; a following MUL 3*5 gives result_lo=0x0F.
REQ-040 The bench SHALL cover, with WIDTH=8 and MULDIV_SIGNED_EN: sgn=1, MUL -6*7 -> {hi,lo}=0xFFD6; DIV -7/2 -> result_lo=0xFD, result_hi=0xFF.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the sequential multiply/divide unit.
//   OP_MUL / OP_DIV : operation encodings on the 2-bit op port (10/11 reserved)
//   state_e         : control FSM states (ST_IDLE, ST_RUN, ST_DONE)
//   clog2()         : ceiling log2, used to size the bit counter
package muldiv_pkg;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < value; p = p << 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/muldiv_fsm.sv
// muldiv_fsm -- control FSM for muldiv_seq: state, bit counter and handshake.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   start_i        : request strobe (only acted on in ST_IDLE)
//   skip_i         : accepted request needs no iterations (error cases)
//   ready_o        : registered, high only in ST_IDLE
//   done_o         : registered, one-cycle pulse in ST_DONE
//   accept_o       : request is being accepted this cycle
//   step_o         : datapath performs one iteration this cycle
//   last_o         : this is the final iteration
module muldiv_fsm
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  input  logic skip_i,
  output logic ready_o,
  output logic done_o,
  output logic accept_o,
  output logic step_o,
  output logic last_o
);

  localparam int unsigned   CW       = clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            ready_q;
  logic            done_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cnt_q   <= '0;
            ready_q <= 1'b0;
            if (skip_i) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign done_o   = done_q;
  assign accept_o = (state_q == ST_IDLE) && start_i;
  assign step_o   = (state_q == ST_RUN);
  assign last_o   = (state_q == ST_RUN) && (cnt_q == LAST_CNT);

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq -- sequential multiplier / divider, one result bit per cycle.
// MUL: shift-add, full 2*WIDTH-bit product. DIV: restoring shift-subtract.
// Optional macro MULDIV_SIGNED_EN adds input sgn for two's complement operands.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start, op, a, b       : request strobe, op (00 MUL, 01 DIV), operands
//   sgn                   : (MULDIV_SIGNED_EN only) signed operation
//   ready, done           : idle indicator, one-cycle completion pulse
//   result_hi, result_lo  : MUL {hi,lo} product; DIV remainder / quotient
//   err                   : divide by zero, reserved op, or signed overflow
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
`ifdef MULDIV_SIGNED_EN
  input  logic             sgn,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             err
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic accept, step, last, skip;
  logic sgn_w;

`ifdef MULDIV_SIGNED_EN
  assign sgn_w = sgn;
`else
  assign sgn_w = 1'b0;
`endif

  // Request decode and operand magnitudes
  logic             is_div_in, div_zero, ovf_in, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_div_in = (op == OP_DIV);
  assign div_zero  = is_div_in && (b == '0);
  assign skip      = op[1] || div_zero;
  assign a_neg     = sgn_w && a[WIDTH-1];
  assign b_neg     = sgn_w && b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign ovf_in    = sgn_w && is_div_in && (a == MIN_NEG) && (b == '1);

  muldiv_fsm #(
    .WIDTH (WIDTH)
  ) u_fsm (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (start),
    .skip_i   (skip),
    .ready_o  (ready),
    .done_o   (done),
    .accept_o (accept),
    .step_o   (step),
    .last_o   (last)
  );

  // Working registers: hi_q accumulates product-high / partial remainder,
  // lo_q holds multiplier / dividend and shifts in product-low / quotient bits.
  logic             is_div_q, neg_ab_q, neg_a_q, ovf_q;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic [WIDTH-1:0] res_hi_q, res_lo_q;
  logic             err_q;

  logic [WIDTH:0]   mul_sum, div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] hi_d, lo_d, fin_hi, fin_lo;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + ({1'b0, opnd_q} & {(WIDTH+1){lo_q[0]}});
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    if (is_div_q) begin
      if (div_ge) begin
        hi_d = WIDTH'(div_shift - {1'b0, opnd_q});
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = div_shift[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

    // Sign correction folded into the last iteration so latency is unchanged.
    fin_hi = hi_d;
    fin_lo = lo_d;
    if (!is_div_q) begin
      if (neg_ab_q) begin
        {fin_hi, fin_lo} = -{hi_d, lo_d};
      end
    end else begin
      if (neg_ab_q) fin_lo = -lo_d;
      if (neg_a_q)  fin_hi = -hi_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_div_q <= 1'b0;
      neg_ab_q <= 1'b0;
      neg_a_q  <= 1'b0;
      ovf_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      is_div_q <= is_div_in;
      neg_ab_q <= a_neg ^ b_neg;
      neg_a_q  <= a_neg;
      ovf_q    <= ovf_in;
      hi_q     <= '0;
      lo_q     <= is_div_in ? a_mag : b_mag;
      opnd_q   <= is_div_in ? b_mag : a_mag;
      // Skipped requests go straight to DONE, so their results load now.
      if (op[1]) begin
        res_hi_q <= '0;
        res_lo_q <= '0;
        err_q    <= 1'b1;
      end else if (div_zero) begin
        res_hi_q <= a;
        res_lo_q <= '1;
        err_q    <= 1'b1;
      end else begin
        res_hi_q <= '0;
        res_lo_q <= '0;
        err_q    <= 1'b0;
      end
    end else if (step) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (last) begin
        res_hi_q <= fin_hi;
        res_lo_q <= fin_lo;
        err_q    <= ovf_q;
      end
    end
  end

  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;
  assign err       = err_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset, start, sgn;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         ready, done, err;
  logic [W-1:0] result_hi, result_lo;

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         err;
    int unsigned  lat;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  muldiv_seq #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
`ifdef MULDIV_SIGNED_EN
    .sgn       (sgn),
`endif
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done      (done),
    .result_hi (result_hi),
    .result_lo (result_lo),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Independent reference using native arithmetic.
  function automatic exp_t model(input string tag, input logic [1:0] o,
                                 input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic s);
    exp_t             e;
    logic [2*W-1:0]   p;
    int               sa, sbv, q, r, sp;
    e.tag = tag;
    e.err = 1'b0;
    e.lat = W + 1;
    e.hi  = '0;
    e.lo  = '0;
`ifndef MULDIV_SIGNED_EN
    s = 1'b0;
`endif
    if (o[1]) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (o == 2'b00) begin
      if (s) begin
        sp = $signed(av) * $signed(bv);
        p  = sp[2*W-1:0];
      end else begin
        p = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
      end
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
    end else if (bv == 0) begin
      e.hi  = av;
      e.lo  = '1;
      e.err = 1'b1;
      e.lat = 1;
    end else if (s) begin
      sa  = $signed(av);
      sbv = $signed(bv);
      if (sa == -(1 << (W - 1)) && sbv == -1) begin
        e.lo  = av;
        e.hi  = '0;
        e.err = 1'b1;
      end else begin
        q    = sa / sbv;
        r    = sa % sbv;
        e.lo = q[W-1:0];
        e.hi = r[W-1:0];
      end
    end else begin
      e.lo = av / bv;
      e.hi = av % bv;
    end
    return e;
  endfunction

  // Called #1 after a rising edge with the DUT idle; returns the same way.
  task automatic do_op(input string tag, input logic [1:0] o,
                       input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo,
                       input logic eerr, input int unsigned elat, input bit repulse);
    exp_t        e;
    int unsigned lat;
    bit          stray;
    check({tag, ":ready"}, ready, 1);
    op = o; a = av; b = bv; sgn = s; start = 1'b1;
    sb_q.push_back('{tag, ehi, elo, eerr, elat});
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom_range(0, 255));
    b = W'($urandom_range(0, 255));
    op = 2'($urandom_range(0, 3));
    sgn = 1'($urandom_range(0, 1));
    lat = 1;
    if (elat > 1) begin
      check({tag, ":run_ready"}, ready, 0);
      check({tag, ":run_cleared"}, {result_hi, result_lo, err}, 0);
    end
    while (done !== 1'b1 && lat < 4 * W) begin
      if (repulse) start = (lat >= 2 && lat <= 4);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, ":latency"}, lat, elat);
    if (done === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.tag, ":hi"}, result_hi, e.hi);
      check({e.tag, ":lo"}, result_lo, e.lo);
      check({e.tag, ":err"}, err, e.err);
      @(posedge clk); #1;
      check({e.tag, ":done_pulse"}, {done, ready}, 2'b01);
      check({e.tag, ":held"}, {result_hi, result_lo, err}, {e.hi, e.lo, e.err});
      if (repulse) begin
        stray = 1'b0;
        repeat (W + 3) begin
          @(posedge clk); #1;
          if (done !== 1'b0 || ready !== 1'b1) stray = 1'b1;
        end
        check({e.tag, ":no_queued_op"}, stray, 0);
      end
    end else begin
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      check({tag, ":no_done"}, done, 1);
    end
  endtask

  initial begin
    exp_t        e;
    logic [1:0]  ro;
    logic [W-1:0] ra, rb;
    logic        rs;
    bit          stray;

    // Reset asserted together with start: reset wins.
    reset = 1'b1; start = 1'b1; op = 2'b00; a = 8'd3; b = 8'd5; sgn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_high", {ready, done, result_hi, result_lo, err}, {1'b1, 1'b0, 16'h0000, 1'b0});
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("rst_after", {ready, done, result_hi, result_lo, err}, {1'b1, 1'b0, 16'h0000, 1'b0});

    do_op("mul13x11", 2'b00, 8'd13,  8'd11, 1'b0, 8'h00, 8'h8F, 1'b0, W + 1, 1'b0);
    do_op("div200_7", 2'b01, 8'd200, 8'd7,  1'b0, 8'h04, 8'h1C, 1'b0, W + 1, 1'b0);
    do_op("div_by0",  2'b01, 8'h55,  8'h00, 1'b0, 8'h55, 8'hFF, 1'b1, 1,     1'b0);
    do_op("mulFFxFF", 2'b00, 8'hFF,  8'hFF, 1'b0, 8'hFE, 8'h01, 1'b0, W + 1, 1'b1);
    do_op("rsv_op",   2'b10, 8'd5,   8'd3,  1'b0, 8'h00, 8'h00, 1'b1, 1,     1'b0);
    do_op("mul_clr",  2'b00, 8'h10,  8'h10, 1'b0, 8'h01, 8'h00, 1'b0, W + 1, 1'b0);
    do_op("div7_9",   2'b01, 8'd7,   8'd9,  1'b0, 8'h07, 8'h00, 1'b0, W + 1, 1'b0);
    do_op("mulFAx7u", 2'b00, 8'hFA,  8'h07, 1'b0, 8'h06, 8'hD6, 1'b0, W + 1, 1'b0);

    // Reset during the 4th RUN cycle aborts the operation.
    op = 2'b00; a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_rst_high", {ready, done, result_hi, result_lo, err}, {1'b1, 1'b0, 16'h0000, 1'b0});
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_after", {ready, done, result_hi, result_lo, err}, {1'b1, 1'b0, 16'h0000, 1'b0});
    stray = 1'b0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (done !== 1'b0) stray = 1'b1;
    end
    check("abort_no_done", stray, 0);
    do_op("mul3x5", 2'b00, 8'd3, 8'd5, 1'b0, 8'h00, 8'h0F, 1'b0, W + 1, 1'b0);

`ifdef MULDIV_SIGNED_EN
    do_op("smul-6x7", 2'b00, 8'hFA, 8'h07, 1'b1, 8'hFF, 8'hD6, 1'b0, W + 1, 1'b0);
    do_op("sdiv-7/2", 2'b01, 8'hF9, 8'h02, 1'b1, 8'hFF, 8'hFD, 1'b0, W + 1, 1'b0);
    do_op("sdiv_ovf", 2'b01, 8'h80, 8'hFF, 1'b1, 8'h00, 8'h80, 1'b1, W + 1, 1'b0);
`endif

    for (int i = 0; i < 12; i++) begin
      ro = ($urandom_range(0, 5) == 0) ? 2'b11 : 2'($urandom_range(0, 1));
      ra = W'($urandom_range(0, 255));
      rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(0, 255));
`ifdef MULDIV_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      e = model($sformatf("rnd%0d", i), ro, ra, rb, rs);
      do_op(e.tag, ro, ra, rb, rs, e.hi, e.lo, e.err, e.lat, 1'b0);
    end

    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
